// File: rtl/dbg_bus_master_pkg.sv
// Shared constants and types for the debug bus master.
// Op codes, state encoding and snapshot geometry live here.
package dbg_bus_pkg;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_SNAP    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR        = 3'd1,
    ST_RD        = 3'd2,
    ST_RSP       = 3'd3,
    ST_SNAP_WR   = 3'd4,
    ST_SNAP_WAIT = 3'd5,
    ST_SNAP_RD   = 3'd6,
    ST_SNAP_RSP  = 3'd7
  } state_e;

  localparam logic [15:0] DBG_CMD_ADDR  = 16'hFFFF;
  localparam logic [15:0] DBG_REG_BASE  = 16'hFF00;
  localparam logic [15:0] ERR_DATA      = 16'hDEAD;
  localparam int          SNAP_WORDS    = 8;
  localparam int          SETTLE_CYCLES = 2;
  localparam int          SNAP_IDX_W    = $clog2(SNAP_WORDS);
  localparam int          SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

  // Command fields captured at acceptance; the op itself is folded into the next state.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  function automatic logic [15:0] snap_addr(input logic [SNAP_IDX_W-1:0] idx);
    return DBG_REG_BASE | 16'(idx);
  endfunction

endpackage

// File: rtl/dbg_bus_master_if.sv
// Host command/response handshake bundle for the debug bus master.
// master = the bus master (consumes commands, produces responses); slave = the host.
interface dbg_bus_master_if;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [1:0]  Cmd_Op;
  logic [15:0] Cmd_Addr;
  logic [15:0] Cmd_Wdata;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [15:0] Rsp_Data;
  logic        Rsp_Last;
  logic        Rsp_Err;

  modport master (
    input  Cmd_Valid, Cmd_Op, Cmd_Addr, Cmd_Wdata, Rsp_Ready,
    output Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Last, Rsp_Err
  );

  modport slave (
    output Cmd_Valid, Cmd_Op, Cmd_Addr, Cmd_Wdata, Rsp_Ready,
    input  Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Last, Rsp_Err
  );
endinterface

// File: rtl/dbg_bus_master_rsp_slot.sv
// Single-entry response holding register; the word stays stable until out_ready.
// The controller only loads it while empty.
module dbg_rsp_slot (
  input  logic        clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        load_last,
  input  logic        load_err,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        out_err
);

  logic        vld_q, vld_d;
  logic [15:0] data_q, data_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    err_d  = err_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      data_d = load_data;
      last_d = load_last;
      err_d  = load_err;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: rtl/dbg_bus_master.sv
// Debug bus master: host commands become single-cycle bus strobes plus responses.
// Build option DBG_SNAPSHOT_EN enables the step+snapshot command (op 10).
module dbg_bus_master
  import dbg_bus_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  dbg_bus_master_if.master host,
  output logic             Read_Reg,
  output logic             Write_Reg,
  output logic [15:0]      MB_Addr,
  inout  wire  [15:0]      MB_Data
);

  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] WR   = ST_WR;
  localparam logic [2:0] RD   = ST_RD;
  localparam logic [2:0] RSP  = ST_RSP;
`ifdef DBG_SNAPSHOT_EN
  localparam logic [2:0] SNAP_WR   = ST_SNAP_WR;
  localparam logic [2:0] SNAP_WAIT = ST_SNAP_WAIT;
  localparam logic [2:0] SNAP_RD   = ST_SNAP_RD;
  localparam logic [2:0] SNAP_RSP  = ST_SNAP_RSP;
`endif

  logic [2:0]  state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        cmd_ready, cmd_acc, rsp_take;
  logic        ld, ld_last, ld_err;
  logic [15:0] ld_data;
  logic        rsp_valid, rsp_last;
`ifdef DBG_SNAPSHOT_EN
  logic [SNAP_IDX_W-1:0] idx_q, idx_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
`endif

  // A new command is only taken once the previous response has drained.
  assign cmd_ready      = (state_q == IDLE) && !rsp_valid;
  assign host.Cmd_Ready = cmd_ready;
  assign cmd_acc        = host.Cmd_Valid && cmd_ready;
  assign rsp_take       = rsp_valid && host.Rsp_Ready;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ld      = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    ld_err  = 1'b0;
`ifdef DBG_SNAPSHOT_EN
    idx_d    = idx_q;
    settle_d = settle_q;
`endif
    case (state_q)
      IDLE: if (cmd_acc) begin
        cmd_d.addr  = host.Cmd_Addr;
        cmd_d.wdata = host.Cmd_Wdata;
        case (host.Cmd_Op)
          OP_READ:  state_d = RD;
          OP_WRITE: state_d = WR;
`ifdef DBG_SNAPSHOT_EN
          OP_SNAP: begin
            state_d  = SNAP_WR;
            idx_d    = '0;
            settle_d = '0;
          end
`endif
          default: begin
            // Rejected ops answer straight from the acceptance edge, no bus cycle.
            ld      = 1'b1;
            ld_data = ERR_DATA;
            ld_last = 1'b1;
            ld_err  = 1'b1;
            state_d = RSP;
          end
        endcase
      end
      RD: begin
        ld      = 1'b1;
        ld_data = MB_Data;
        ld_last = 1'b1;
        state_d = RSP;
      end
      WR: begin
        ld      = 1'b1;
        ld_data = cmd_q.wdata;
        ld_last = 1'b1;
        state_d = RSP;
      end
      RSP: if (rsp_take) state_d = IDLE;
`ifdef DBG_SNAPSHOT_EN
      SNAP_WR: state_d = SNAP_WAIT;
      SNAP_WAIT: begin
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_d = SNAP_RD;
        else settle_d = settle_q + 1'b1;
      end
      SNAP_RD: begin
        ld      = 1'b1;
        ld_data = MB_Data;
        ld_last = (idx_q == '1);
        idx_d   = idx_q + 1'b1;
        state_d = SNAP_RSP;
      end
      SNAP_RSP: if (rsp_take) state_d = rsp_last ? IDLE : SNAP_RD;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Read_Reg  = 1'b0;
    Write_Reg = 1'b0;
    MB_Addr   = '0;
    case (state_q)
      RD: begin
        Read_Reg = 1'b1;
        MB_Addr  = cmd_q.addr;
      end
      WR: begin
        Write_Reg = 1'b1;
        MB_Addr   = cmd_q.addr;
      end
`ifdef DBG_SNAPSHOT_EN
      SNAP_WR: begin
        Write_Reg = 1'b1;
        MB_Addr   = DBG_CMD_ADDR;
      end
      SNAP_RD: begin
        Read_Reg = 1'b1;
        MB_Addr  = snap_addr(idx_q);
      end
`endif
      default: ;
    endcase
  end

  assign MB_Data = Write_Reg ? cmd_q.wdata : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
`ifdef DBG_SNAPSHOT_EN
      idx_q    <= '0;
      settle_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DBG_SNAPSHOT_EN
      idx_q    <= idx_d;
      settle_q <= settle_d;
`endif
    end
    cmd_q <= cmd_d;
  end

  dbg_rsp_slot u_rsp_slot (
    .clk       (clk),
    .Reset     (Reset),
    .load      (ld),
    .load_data (ld_data),
    .load_last (ld_last),
    .load_err  (ld_err),
    .out_ready (host.Rsp_Ready),
    .out_valid (rsp_valid),
    .out_data  (host.Rsp_Data),
    .out_last  (rsp_last),
    .out_err   (host.Rsp_Err)
  );

  assign host.Rsp_Valid = rsp_valid;
  assign host.Rsp_Last  = rsp_last;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Self-checking bench for dbg_bus_master with a debug-slave model on MB_Data.
// Snapshot scenarios are compiled in when DBG_SNAPSHOT_EN is defined.
module tb_dbg_bus_master;
  import dbg_bus_pkg::*;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  dbg_bus_master_if hif();
  logic        Read_Reg, Write_Reg;
  logic [15:0] MB_Addr;
  wire  [15:0] MB_Data;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] slave_rd(input logic [15:0] a);
    if (a == 16'hFF07) return 16'h55AA;
    return {a[7:0], ~a[15:8]} ^ 16'h1357;
  endfunction

  assign MB_Data = Read_Reg ? slave_rd(MB_Addr) : 16'hzzzz;

  dbg_bus_master dut (
    .clk       (clk),
    .Reset     (Reset),
    .host      (hif),
    .Read_Reg  (Read_Reg),
    .Write_Reg (Write_Reg),
    .MB_Addr   (MB_Addr),
    .MB_Data   (MB_Data)
  );

  wire [17:0] bus_obs = {Read_Reg, Write_Reg, MB_Addr};
  wire [18:0] rsp_obs = {hif.Rsp_Valid, hif.Rsp_Last, hif.Rsp_Err, hif.Rsp_Data};

  typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; } bus_ev_t;
  typedef struct { logic [15:0] data; logic last; logic err; } rsp_ev_t;
  bus_ev_t bq[$];
  rsp_ev_t rq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    hif.Cmd_Valid = 1'b1;
    hif.Cmd_Op    = op;
    hif.Cmd_Addr  = a;
    hif.Cmd_Wdata = d;
    while (hif.Cmd_Ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (hif.Cmd_Ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_accept: Cmd_Ready=%b after %0d cycles, want 1", hif.Cmd_Ready, n);
    end
    step();
    hif.Cmd_Valid = 1'b0;
    hif.Cmd_Op    = 2'($urandom);
    hif.Cmd_Addr  = 16'($urandom);
    hif.Cmd_Wdata = 16'($urandom);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    vectors++;
    if (bus_obs !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h want 0", bus_obs);
    end
    vectors++;
    if (rsp_obs !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: got %h want 0", rsp_obs);
    end
    Reset = 1'b0;
    step();
    vectors++;
    if (hif.Cmd_Ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", hif.Cmd_Ready);
    end
  endtask

  task automatic test_read();
    hif.Rsp_Ready = 1'b1;
    do_cmd(OP_READ, 16'hFF07, 16'h1234);
    vectors++;
    if ({bus_obs, hif.Rsp_Valid} !== {1'b1, 1'b0, 16'hFF07, 1'b0}) begin
      miscompares++;
      $display("FAIL read_strobe: got %h/%b want 2ff07/0", bus_obs, hif.Rsp_Valid);
    end
    step();
    vectors++;
    if ({rsp_obs, bus_obs} !== {1'b1, 1'b1, 1'b0, 16'h55AA, 18'h0}) begin
      miscompares++;
      $display("FAIL read_rsp: got %h/%h want 655aa/0", rsp_obs, bus_obs);
    end
    step();
    vectors++;
    if ({hif.Rsp_Valid, hif.Cmd_Ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL read_done: got %b%b want 01", hif.Rsp_Valid, hif.Cmd_Ready);
    end
  endtask

  task automatic test_write();
    hif.Rsp_Ready = 1'b1;
    do_cmd(OP_WRITE, 16'hFFFF, 16'h0006);
    vectors++;
    if ({bus_obs, MB_Data} !== {1'b0, 1'b1, 16'hFFFF, 16'h0006}) begin
      miscompares++;
      $display("FAIL write_strobe: got %h data %h want 1ffff data 0006", bus_obs, MB_Data);
    end
    step();
    vectors++;
    if ({rsp_obs, bus_obs} !== {1'b1, 1'b1, 1'b0, 16'h0006, 18'h0}) begin
      miscompares++;
      $display("FAIL write_ack: got %h/%h want 60006/0", rsp_obs, bus_obs);
    end
    step();
  endtask

  task automatic test_illegal(input logic [1:0] op);
    hif.Rsp_Ready = 1'b1;
    do_cmd(op, 16'($urandom), 16'($urandom));
    vectors++;
    if ({rsp_obs, bus_obs} !== {1'b1, 1'b1, 1'b1, 16'hDEAD, 18'h0}) begin
      miscompares++;
      $display("FAIL illegal_rsp op%b: got %h/%h want 7dead/0", op, rsp_obs, bus_obs);
    end
    step();
    vectors++;
    if ({hif.Rsp_Valid, bus_obs} !== 19'h0) begin
      miscompares++;
      $display("FAIL illegal_after op%b: got %b/%h want 0/0", op, hif.Rsp_Valid, bus_obs);
    end
  endtask

  task automatic test_reset_pending();
    logic [15:0] a;
    logic [18:0] held;
    a = 16'($urandom);
    hif.Rsp_Ready = 1'b0;
    do_cmd(OP_READ, a, 16'h0);
    step();
    held = rsp_obs;
    vectors++;
    if (held !== {1'b1, 1'b1, 1'b0, slave_rd(a)}) begin
      miscompares++;
      $display("FAIL stall_rsp: got %h want %h", held, {1'b1, 1'b1, 1'b0, slave_rd(a)});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({rsp_obs, bus_obs} !== {held, 18'h0}) begin
        miscompares++;
        $display("FAIL stall_hold: got %h/%h want %h/0", rsp_obs, bus_obs, held);
      end
    end
    Reset = 1'b1;
    step();
    vectors++;
    if ({rsp_obs, bus_obs} !== 37'h0) begin
      miscompares++;
      $display("FAIL reset_drop: got %h/%h want 0/0", rsp_obs, bus_obs);
    end
    // Reset and an acceptable command on the same edge: reset wins.
    hif.Cmd_Valid = 1'b1;
    hif.Cmd_Op    = OP_READ;
    hif.Cmd_Addr  = 16'h1234;
    step();
    Reset = 1'b0;
    hif.Cmd_Valid = 1'b0;
    step();
    vectors++;
    if ({bus_obs, hif.Rsp_Valid, hif.Cmd_Ready} !== {18'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_priority: got %h/%b/%b want 0/0/1", bus_obs, hif.Rsp_Valid, hif.Cmd_Ready);
    end
  endtask

`ifdef DBG_SNAPSHOT_EN
  task automatic test_snapshot();
    hif.Rsp_Ready = 1'b1;
    do_cmd(OP_SNAP, 16'h1234, 16'h0002);
    vectors++;
    if ({bus_obs, MB_Data} !== {1'b0, 1'b1, 16'hFFFF, 16'h0002}) begin
      miscompares++;
      $display("FAIL snap_write: got %h data %h want 1ffff data 0002", bus_obs, MB_Data);
    end
    for (int k = 0; k < SETTLE_CYCLES; k++) begin
      step();
      vectors++;
      if ({bus_obs, hif.Rsp_Valid} !== 19'h0) begin
        miscompares++;
        $display("FAIL snap_settle%0d: got %h/%b want 0/0", k, bus_obs, hif.Rsp_Valid);
      end
    end
    for (int i = 0; i < SNAP_WORDS; i++) begin
      step();
      vectors++;
      if (bus_obs !== {1'b1, 1'b0, 16'hFF00 + 16'(i)}) begin
        miscompares++;
        $display("FAIL snap_rd%0d: got %h want %h", i, bus_obs, {1'b1, 1'b0, 16'hFF00 + 16'(i)});
      end
      step();
      vectors++;
      if (rsp_obs !== {1'b1, (i == 7), 1'b0, slave_rd(16'hFF00 + 16'(i))}) begin
        miscompares++;
        $display("FAIL snap_rsp%0d: got %h want %h", i, rsp_obs, {1'b1, (i == 7), 1'b0, slave_rd(16'hFF00 + 16'(i))});
      end
    end
    step();
    vectors++;
    if ({hif.Rsp_Valid, hif.Cmd_Ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL snap_done: got %b%b want 01", hif.Rsp_Valid, hif.Cmd_Ready);
    end
  endtask

  task automatic test_back_pressure();
    logic [18:0] held;
    int n = 0;
    hif.Rsp_Ready = 1'b1;
    do_cmd(OP_SNAP, 16'h0, 16'h0002);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) hif.Rsp_Ready = 1'b0;
      step();
    end
    held = rsp_obs;
    vectors++;
    if (held !== {1'b1, 1'b0, 1'b0, slave_rd(16'hFF03)}) begin
      miscompares++;
      $display("FAIL bp_word3: got %h want %h", held, {1'b1, 1'b0, 1'b0, slave_rd(16'hFF03)});
    end
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if ({rsp_obs, bus_obs} !== {held, 18'h0}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got %h/%h want %h/0", k, rsp_obs, bus_obs, held);
      end
    end
    hif.Rsp_Ready = 1'b1;
    step();
    vectors++;
    if (bus_obs !== {1'b1, 1'b0, 16'hFF04}) begin
      miscompares++;
      $display("FAIL bp_resume: got %h want 2ff04", bus_obs);
    end
    step();
    vectors++;
    if (rsp_obs !== {1'b1, 1'b0, 1'b0, slave_rd(16'hFF04)}) begin
      miscompares++;
      $display("FAIL bp_word4: got %h want %h", rsp_obs, {1'b1, 1'b0, 1'b0, slave_rd(16'hFF04)});
    end
    while (hif.Cmd_Ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset_mid_snapshot();
    hif.Rsp_Ready = 1'b1;
    do_cmd(OP_SNAP, 16'h0, 16'h0002);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      step();
    end
    step();
    vectors++;
    if (bus_obs !== {1'b1, 1'b0, 16'hFF04}) begin
      miscompares++;
      $display("FAIL mid_word4: got %h want 2ff04", bus_obs);
    end
    Reset = 1'b1;
    step();
    vectors++;
    if ({rsp_obs, bus_obs} !== 37'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got %h/%h want 0/0", rsp_obs, bus_obs);
    end
    Reset = 1'b0;
    step();
    vectors++;
    if ({hif.Cmd_Ready, bus_obs, hif.Rsp_Valid} !== {1'b1, 18'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_release: got %b/%h/%b want 1/0/0", hif.Cmd_Ready, bus_obs, hif.Rsp_Valid);
    end
  endtask
`endif

  // Reference: expected bus events and response words for one accepted command.
  task automatic model_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    case (op)
      OP_READ: begin
        bq.push_back('{wr: 1'b0, addr: a, data: 16'h0});
        rq.push_back('{data: slave_rd(a), last: 1'b1, err: 1'b0});
      end
      OP_WRITE: begin
        bq.push_back('{wr: 1'b1, addr: a, data: d});
        rq.push_back('{data: d, last: 1'b1, err: 1'b0});
      end
`ifdef DBG_SNAPSHOT_EN
      OP_SNAP: begin
        bq.push_back('{wr: 1'b1, addr: 16'hFFFF, data: d});
        for (int i = 0; i < 8; i++) begin
          bq.push_back('{wr: 1'b0, addr: 16'hFF00 + 16'(i), data: 16'h0});
          rq.push_back('{data: slave_rd(16'hFF00 + 16'(i)), last: (i == 7), err: 1'b0});
        end
      end
`endif
      default: rq.push_back('{data: 16'hDEAD, last: 1'b1, err: 1'b1});
    endcase
  endtask

  task automatic test_random();
    logic [18:0] prev_rsp = '0;
    bit          prev_stall = 1'b0;
    bit          cmd_on = 1'b0;
    int          remaining = 40;
    int          cyc = 0;
    bus_ev_t     be;
    rsp_ev_t     re;
    while ((remaining > 0 || cmd_on || rq.size() > 0) && cyc < 5000) begin
      if (!cmd_on && remaining > 0 && $urandom_range(0, 2) == 0) begin
        cmd_on = 1'b1;
        hif.Cmd_Valid = 1'b1;
        hif.Cmd_Op    = 2'($urandom_range(0, 3));
        hif.Cmd_Addr  = ($urandom_range(0, 1) == 1) ? (16'hFF00 | 16'($urandom_range(0, 7))) : 16'($urandom);
        hif.Cmd_Wdata = 16'($urandom);
      end
      hif.Rsp_Ready = ($urandom_range(0, 9) < 7);
      if (prev_stall) begin
        vectors++;
        if (rsp_obs !== prev_rsp) begin
          miscompares++;
          $display("FAIL rnd_stable cyc%0d: got %h want %h", cyc, rsp_obs, prev_rsp);
        end
      end
      vectors++;
      if (!Read_Reg && !Write_Reg) begin
        if (MB_Addr !== 16'h0) begin
          miscompares++;
          $display("FAIL rnd_idle_addr cyc%0d: got %h want 0000", cyc, MB_Addr);
        end
      end else if (bq.size() == 0) begin
        miscompares++;
        $display("FAIL rnd_bus cyc%0d: unexpected strobe %h, want none", cyc, bus_obs);
      end else begin
        be = bq.pop_front();
        if (bus_obs !== {~be.wr, be.wr, be.addr} || (be.wr && MB_Data !== be.data)) begin
          miscompares++;
          $display("FAIL rnd_bus cyc%0d: got %h data %h want %h data %h", cyc, bus_obs, MB_Data, {~be.wr, be.wr, be.addr}, be.data);
        end
        if (Read_Reg) begin
          vectors++;
          if (hif.Rsp_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_rd_pending cyc%0d: Rsp_Valid=%b during read, want 0", cyc, hif.Rsp_Valid);
          end
        end
      end
      if (hif.Rsp_Valid === 1'b1 && hif.Rsp_Ready) begin
        vectors++;
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_rsp cyc%0d: unexpected response %h, want none", cyc, rsp_obs);
        end else begin
          re = rq.pop_front();
          if ({hif.Rsp_Last, hif.Rsp_Err, hif.Rsp_Data} !== {re.last, re.err, re.data}) begin
            miscompares++;
            $display("FAIL rnd_rsp cyc%0d: got %h want %h", cyc, {hif.Rsp_Last, hif.Rsp_Err, hif.Rsp_Data}, {re.last, re.err, re.data});
          end
        end
      end
      prev_stall = (hif.Rsp_Valid === 1'b1) && !hif.Rsp_Ready;
      prev_rsp   = rsp_obs;
      if (cmd_on && hif.Cmd_Ready === 1'b1) begin
        model_cmd(hif.Cmd_Op, hif.Cmd_Addr, hif.Cmd_Wdata);
        cmd_on = 1'b0;
        remaining--;
      end
      step();
      if (!cmd_on) hif.Cmd_Valid = 1'b0;
      cyc++;
    end
    vectors++;
    if (cyc >= 5000 || bq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain: cycles %0d, bus left %0d, rsp left %0d, want <5000/0/0", cyc, bq.size(), rq.size());
    end
  endtask

  initial begin
    Reset         = 1'b1;
    hif.Cmd_Valid = 1'b0;
    hif.Cmd_Op    = 2'b00;
    hif.Cmd_Addr  = 16'h0;
    hif.Cmd_Wdata = 16'h0;
    hif.Rsp_Ready = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_illegal(OP_ILLEGAL);
`ifndef DBG_SNAPSHOT_EN
    test_illegal(OP_SNAP);
`endif
    test_reset_pending();
`ifdef DBG_SNAPSHOT_EN
    test_snapshot();
    test_back_pressure();
    test_reset_mid_snapshot();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dbg_bus_master.md
DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset Reset, synchronous, active-high; clock clk.
REQ-003 SHALL have port Cmd_Valid, input, 1 bit: host command present.
REQ-004 SHALL have port Cmd_Ready, output, 1 bit: command accepted when Cmd_Valid && Cmd_Ready at a clk edge.
REQ-005 SHALL have port Cmd_Op, input, 2 bits: 00 read, 01 write, 10 step+snapshot, 11 illegal.
REQ-006 SHALL have port Cmd_Addr, input, 16 bits: bus address for read and write.
REQ-007 SHALL have port Cmd_Wdata, input, 16 bits: write data, or the command-register word for a snapshot.
REQ-008 SHALL have port Rsp_Valid, output, 1 bit: response word present.
REQ-009 SHALL have port Rsp_Ready, input, 1 bit: response consumed when Rsp_Valid && Rsp_Ready.
REQ-010 SHALL have port Rsp_Data, output, 16 bits: response word.
REQ-011 SHALL have port Rsp_Last, output, 1 bit: final word of the current command.
REQ-012 SHALL have port Rsp_Err, output, 1 bit: command rejected.
REQ-013 SHALL have port Read_Reg, output, 1 bit: bus read strobe.
REQ-014 SHALL have port Write_Reg, output, 1 bit: bus write strobe.
REQ-015 SHALL have port MB_Addr, output, 16 bits: bus address.
REQ-016 SHALL have port MB_Data, inout, 16 bits: driven only while Write_Reg=1, high-Z otherwise.

Function
REQ-017 SHALL use states IDLE, WR, RD, RSP, SNAP_WR, SNAP_WAIT, SNAP_RD, SNAP_RSP.
REQ-018 SHALL assert Cmd_Ready only in IDLE with Rsp_Valid=0.
REQ-019 SHALL register Cmd_Op, Cmd_Addr and Cmd_Wdata on acceptance, so host inputs are don't-care afterwards.
REQ-020 Read SHALL assert Read_Reg with MB_Addr=Cmd_Addr for exactly one cycle, starting the cycle after acceptance.
REQ-021 Read SHALL capture MB_Data at the edge ending that strobe cycle.
REQ-022 Read SHALL present Rsp_Valid=1, Rsp_Last=1 on the next cycle, giving 2 cycles from acceptance to Rsp_Valid.
REQ-023 Write SHALL assert Write_Reg for one cycle with MB_Addr=Cmd_Addr and MB_Data=Cmd_Wdata.
REQ-024 Write SHALL then return one ack response: Rsp_Data=Cmd_Wdata, Rsp_Last=1.
REQ-025 Snapshot SHALL write Cmd_Wdata to address 16'hFFFF for one cycle (SNAP_WR).
REQ-026 Snapshot SHALL then idle with no strobes for SETTLE_CYCLES=2 cycles (SNAP_WAIT).
REQ-027 Snapshot SHALL then read 16'hFF00..16'hFF07 in order, each read followed by its response (SNAP_RD/SNAP_RSP).
REQ-028 Snapshot SHALL set Rsp_Last only on the 16'hFF07 word; a 3-bit index wrapping 7->0 ends the sequence.
REQ-029 Rsp_Valid, Rsp_Data, Rsp_Last and Rsp_Err SHALL hold stable until Rsp_Ready; no next bus read is issued while a response is pending.
REQ-030 SHALL never assert Read_Reg and Write_Reg in the same cycle.
REQ-031 SHALL drive MB_Addr=16'h0000 whenever no strobe is active.
REQ-032 Op 11 SHALL produce no bus cycle and give one response: Rsp_Data=16'hDEAD, Rsp_Err=1, Rsp_Last=1, valid 1 cycle after acceptance.
REQ-033 SHALL return to IDLE after a response with Rsp_Last=1 is consumed.

Reset
REQ-034 On Reset=1 at a clk edge, SHALL enter IDLE and drop any in-flight command, including one mid-snapshot.
REQ-035 Reset values: Read_Reg=0, Write_Reg=0, MB_Addr=0, MB_Data high-Z, Rsp_Valid=0, Rsp_Data=0, Rsp_Last=0, Rsp_Err=0, snapshot index=0.
REQ-036 Cmd_Ready SHALL be 1 in the first cycle after Reset deasserts.
REQ-037 Reset SHALL take priority over a simultaneous command acceptance.

Configuration
REQ-038 With DBG_SNAPSHOT_EN defined, op 10 SHALL perform REQ-025..REQ-028.
REQ-039 Without DBG_SNAPSHOT_EN, op 10 SHALL behave as op 11, and the SNAP_* states and index counter SHALL be absent.

Structure
REQ-040 Package dbg_bus_pkg SHALL hold: op-code constants, state enum, DBG_CMD_ADDR=16'hFFFF, DBG_REG_BASE=16'hFF00, SNAP_WORDS=8, SETTLE_CYCLES=2, ERR_DATA=16'hDEAD.
REQ-041 SHALL contain one sub-module, dbg_rsp_slot: a single-entry response holding register with valid/ready handshake.

Verification
REQ-042 Read at 16'hFF07 against the debug slave -> Read_Reg high 1 cycle, then Rsp_Data=16'h55AA, Rsp_Last=1, Rsp_Err=0.
REQ-043 Write 16'h0006 to 16'hFFFF -> Write_Reg high 1 cycle, MB_Data=16'h0006 only in that cycle, ack Rsp_Data=16'h0006.
REQ-044 Snapshot with Cmd_Wdata=16'h0002 and Rsp_Ready=1 -> 1 write, 2 quiet cycles, 8 responses from FF00..FF07, Rsp_Last only on the 8th (16'h55AA).
REQ-045 Snapshot with Rsp_Ready held low 5 cycles on word 3 -> outputs stable, no Read_Reg pulse until accepted, word 4 then follows.
REQ-046 Op 11 -> no strobes, Rsp_Data=16'hDEAD, Rsp_Err=1; without DBG_SNAPSHOT_EN, op 10 gives the same.
REQ-047 Reset asserted during snapshot word 4 -> next cycle Rsp_Valid=0, strobes 0, MB_Data Z, Cmd_Ready=1 after release.
